// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encodings,
// default operand width and the iteration-counter width helper.
package div_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Counter must hold WIDTH-1; guard the degenerate single-bit case.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/restoring_divider_if.sv
// Start/done handshake and operand/result bus of the restoring divider.
// Optional macro DIV_ZERO_DETECT_EN adds the dz flag to the bus.
interface restoring_divider_if #(parameter int WIDTH = div_pkg::DEF_WIDTH);

  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz;

  modport master (output start, X, Y, input Q, R, busy, done, dz);
  modport slave  (input start, X, Y, output Q, R, busy, done, dz);
`else
  modport master (output start, X, Y, input Q, R, busy, done);
  modport slave  (input start, X, Y, output Q, R, busy, done);
`endif

endinterface

// File: rtl/trial_subtractor.sv
// Combinational (W+1)-bit trial subtraction: partial remainder minus the
// zero-extended divisor, formed as an add of the inverted divisor with
// carry-in 1. The difference MSB is the borrow because the remainder is
// always below twice the divisor.
module trial_subtractor #(
  parameter int W = 4
) (
  input  logic [W:0]   i_a,
  input  logic [W-1:0] i_b,
  output logic [W:0]   o_diff,
  output logic         o_borrow
);

  logic [W:0] w_b_inv;

  assign w_b_inv  = ~{1'b0, i_b};
  assign o_diff   = i_a + w_b_inv + {{W{1'b0}}, 1'b1};
  assign o_borrow = o_diff[W];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Handshake outputs (busy/done/Q/R/dz) are registered one cycle behind the
// internal FSM, so done rises WIDTH+1 edges after the accepted start edge.
// Optional macro DIV_ZERO_DETECT_EN: divide-by-zero skips RUN and raises dz.
module restoring_divider import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst,
  restoring_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_zero;
`ifdef DIV_ZERO_DETECT_EN
  logic             r_zero;
  logic             r_dz;
`endif

  assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
`ifdef DIV_ZERO_DETECT_EN
  assign w_zero = (bus.Y == {WIDTH{1'b0}});
`else
  assign w_zero = 1'b0;
`endif

  trial_subtractor #(.W(WIDTH)) u_sub (
    .i_a      (w_shift),
    .i_b      (r_div),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state: start only counts in IDLE; zero divisor may bypass RUN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = w_zero ? DONE : RUN;
        else           w_next = IDLE;
      end
      RUN: begin
        if (r_cnt == {CW{1'b0}}) w_next = DONE;
        else                     w_next = RUN;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/trial-subtract iterations, result latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= {(WIDTH+1){1'b0}};
      r_dvd <= {WIDTH{1'b0}};
      r_div <= {WIDTH{1'b0}};
      r_cnt <= {CW{1'b0}};
      r_q   <= {WIDTH{1'b0}};
      r_r   <= {WIDTH{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
      r_zero <= 1'b0;
      r_dz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_dvd <= bus.X;
            r_div <= bus.Y;
            r_rem <= {(WIDTH+1){1'b0}};
            r_cnt <= CW'(WIDTH-1);
`ifdef DIV_ZERO_DETECT_EN
            r_dz   <= 1'b0;
            r_zero <= w_zero;
            // Zero divisor: preload the architectural result directly.
            if (w_zero) begin
              r_dvd <= {WIDTH{1'b1}};
              r_rem <= {1'b0, bus.X};
            end
`endif
          end
        end
        RUN: begin
          r_rem <= w_borrow ? w_shift : w_diff;
          r_dvd <= {r_dvd[WIDTH-2:0], ~w_borrow};
          r_cnt <= r_cnt - CW'(1);
        end
        DONE: begin
          r_q <= r_dvd;
          r_r <= r_rem[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
          r_dz <= r_zero;
`endif
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Registered handshake flags, one cycle behind the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (r_state == RUN);
      r_done <= (r_state == DONE);
    end
  end

  assign bus.Q    = r_q;
  assign bus.R    = r_r;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.dz   = r_dz;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4): directed cases,
// ignored-start and async-reset scenarios, exhaustive sweep and random runs,
// all compared against a plain-arithmetic reference model.
module tb_restoring_divider;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  restoring_divider_if #(.WIDTH(4)) bus ();

  restoring_divider #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] x, input logic [3:0] y,
                                output logic [3:0] q, output logic [3:0] r);
    if (y == 4'd0) begin
      q = 4'hF;
      r = x;
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // One division; inject>0 pulses a competing start (7/1) before edge 'inject'.
  task automatic run_div(input logic [3:0] x, input logic [3:0] y, input int inject, input string tag);
    logic [3:0] exp_q, exp_r, prev_q, prev_r;
    int lat, busy_n, overlap, moved, exp_lat, exp_busy, extra;
    model(x, y, exp_q, exp_r);
    exp_lat  = 5;
    exp_busy = 4;
`ifdef DIV_ZERO_DETECT_EN
    if (y == 4'd0) begin
      exp_lat  = 1;
      exp_busy = 0;
    end
`endif
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = x;
    bus.Y     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    prev_q  = bus.Q;
    prev_r  = bus.R;
    lat     = 0;
    busy_n  = 0;
    overlap = 0;
    moved   = 0;
    for (int n = 1; n <= 12; n++) begin
      if (inject > 0 && n == inject) begin
        bus.start = 1'b1;
        bus.X     = 4'd7;
        bus.Y     = 4'd1;
      end
      if (inject > 0 && n == inject + 1) bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (bus.busy) busy_n++;
      if (bus.busy && bus.done) overlap++;
      if (!bus.done && (bus.Q != prev_q || bus.R != prev_r)) moved++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_lat"},     lat,     exp_lat);
    chk({tag, "_q"},       bus.Q,   exp_q);
    chk({tag, "_r"},       bus.R,   exp_r);
    chk({tag, "_busy_n"},  busy_n,  exp_busy);
    chk({tag, "_overlap"}, overlap, 0);
    chk({tag, "_hold"},    moved,   0);
`ifdef DIV_ZERO_DETECT_EN
    chk({tag, "_dz"}, bus.dz, (y == 4'd0) ? 1 : 0);
`endif
    if (inject > 0) begin
      extra = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        if (bus.done) extra++;
      end
      chk({tag, "_extra_done"}, extra, 0);
      chk({tag, "_q_hold"},     bus.Q, exp_q);
    end
  endtask

  initial begin
    logic [3:0] rx, ry;
    n_chk     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.X     = 4'd0;
    bus.Y     = 4'd0;
    #2;
    chk("rst_q",    bus.Q,    0);
    chk("rst_r",    bus.R,    0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
`ifdef DIV_ZERO_DETECT_EN
    chk("rst_dz",   bus.dz,   0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_div(4'd13, 4'd4,  0, "d13_4");
    run_div(4'd2,  4'd3,  0, "d2_3");
    run_div(4'd15, 4'd1,  0, "d15_1");
    run_div(4'd15, 4'd15, 0, "d15_15");
    run_div(4'd0,  4'd7,  0, "d0_7");
    run_div(4'd9,  4'd0,  0, "d9_0");
    run_div(4'd6,  4'd2,  0, "d6_2");
    run_div(4'd12, 4'd5,  2, "ign");

    // Async reset in RUN cycle 2 of 14/3.
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 4'd14;
    bus.Y     = 4'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_q",    bus.Q,    0);
    chk("arst_r",    bus.R,    0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    run_div(4'd14, 4'd3, 0, "d14_3");

    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 1; yi < 16; yi++) begin
        run_div(4'(xi), 4'(yi), 0, "sweep");
      end
    end

    for (int k = 0; k < 40; k++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      run_div(rx, ry, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
